dis_scan_compositor: RTL
========================

Name: dis_scan_compositor

Overview:
Drives the paint interface of all sprite/layer renderers in the display path. It generates the paint_x/paint_y scan coordinates for one frame and collects each layer's paint_enable/paint_color after the fixed render-pipeline latency. It resolves layer priority and streams the final pixels to the LCD/framebuffer writer over a valid/ready handshake. Credit-based issue keeps the free-running layer pipelines from overflowing when the sink stalls.

Parameters:
SCREEN_X, 480, pixels per line (x is the fast scan axis)
SCREEN_Y, 800, lines per frame
LAYER_NUM, 4, number of layer inputs; layer 0 has the highest priority
PIPE_LAT, 4, cycles from paint_x/paint_y to that coordinate's layer_enable/layer_color
FIFO_DEPTH, 8, output pixel FIFO entries; must be >= PIPE_LAT+2
BG_COLOR, 16'h0000, colour emitted when no layer is enabled

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  frame request pulse; sampled only in IDLE
paint_x  out  16  signed scan x broadcast to layers
paint_y  out  16  signed scan y broadcast to layers
layer_enable  in  LAYER_NUM  per-layer pixel hit, aligned PIPE_LAT after the coordinate
layer_color  in  16*LAYER_NUM  per-layer RGB565; layer i occupies [16*i+15:16*i]
pix_data  out  16  composited pixel
pix_valid  out  1  pix_data valid
pix_ready  in  1  sink accepts the pixel when pix_valid && pix_ready
pix_last  out  1  marks the final pixel of the frame (x=SCREEN_X-1, y=SCREEN_Y-1)
busy  out  1  high from the start of a frame until frame_done
frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset: FSM to IDLE; paint_x, paint_y, pix_data = 0; pix_valid, pix_last, busy, frame_done = 0; FIFO empty; in-flight tracker cleared. A reset mid-frame aborts the frame and emits no frame_done.
- FSM states:
  - IDLE: on start, go to SCAN with x=0, y=0, busy=1.
  - SCAN: issues coordinates. After issuing (SCREEN_X-1, SCREEN_Y-1), go to DRAIN.
  - DRAIN: wait until no coordinate is in flight, the FIFO is empty, and the last beat has been accepted. Then pulse frame_done for one cycle, go to IDLE, and set busy=0 in that same cycle.
  - start is ignored outside IDLE.
- Issue rule (SCAN only): issue when fifo_count + inflight < FIFO_DEPTH, using current-cycle values. A pop in the same cycle is not credited.
  - On issue: paint_x/paint_y take the coordinate, and a 1 enters a PIPE_LAT-deep valid shift register.
  - When not issuing: paint_x/paint_y hold their value and a 0 enters the shift register.
  - inflight = popcount of the shift register.
- Scan order: x increments each issue. At x=SCREEN_X-1, x wraps to 0 and y increments. No gaps at a wrap.
- Capture: when the shift-register tail is 1, composite and push into the FIFO.
  - Composited colour = layer_color of the lowest index i with layer_enable[i]=1; BG_COLOR if none.
  - pix_last is stored with the entry.
  - The credit rule guarantees no overflow. Samples whose tail bit is 0 are discarded.
- Latency: a coordinate issued at cycle t reaches pix_valid no earlier than t+PIPE_LAT+1, since the FIFO output is registered.
- Throughput: 1 pixel/cycle while pix_ready=1.
- Handshake: while pix_valid=1, pix_data/pix_last stay stable until accepted. pix_valid never drops without acceptance.
- Widths: x/y counters are 16-bit; SCREEN_X and SCREEN_Y must each be <= 32767.

Test Plan:
- SCREEN_X=4, SCREEN_Y=3, pix_ready=1, all layer_enable=0, start at cycle 0: 12 beats, all BG_COLOR, in order (0,0),(1,0),…,(3,2). First pix_valid at cycle PIPE_LAT+2 from start, back-to-back thereafter. pix_last only on beat 12. frame_done one cycle after beat 12 is accepted.
- Layer model returns, for coordinate (x,y), layer0 enable when x==1 with colour 16'hF800, and layer2 always enabled with colour 16'h001F: x==1 pixels = F800, all others = 001F.
- pix_ready held 0 for 20 cycles mid-frame: no more than FIFO_DEPTH pixels are buffered and issue stops. On release, the stream resumes with no lost, duplicated, or reordered pixels (check against the coordinate-derived colour).
- Random pix_ready (50%) over a full 480x800 frame: exactly 384000 beats, each matching the reference composite, then a single frame_done.
- start pulsed again during SCAN and DRAIN: ignored, and the frame count stays 1. start on the cycle after frame_done: a new frame begins at (0,0).
- rst asserted mid-SCAN with the FIFO non-empty: next cycle pix_valid=0, busy=0, paint_x/paint_y=0, and no frame_done. The following start produces a clean full frame.

Source files
------------

// File: rtl/dis_scan_compositor.sv
// Scan coordinate generator and layer priority compositor: credit-limited issue into the
// layer pipelines, priority resolve at capture, and a registered-output pixel FIFO to the sink.
module dis_scan_compositor #(
   parameter int unsigned SCREEN_X   = 480,
   parameter int unsigned SCREEN_Y   = 800,
   parameter int unsigned LAYER_NUM  = 4,
   parameter int unsigned PIPE_LAT   = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] BG_COLOR   = 16'h0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic signed [15:0]      paint_x,
   output logic signed [15:0]      paint_y,
   input  logic [LAYER_NUM-1:0]    layer_enable,
   input  logic [16*LAYER_NUM-1:0] layer_color,
   output logic [15:0]             pix_data,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic                    pix_last,
   output logic                    busy,
   output logic                    frame_done
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [15:0] X_MAX = 16'(SCREEN_X - 1);
   localparam logic [15:0] Y_MAX = 16'(SCREEN_Y - 1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [15:0]           x_q, x_d, y_q, y_d;
   logic [15:0]           paint_x_q, paint_x_d, paint_y_q, paint_y_d;
   logic [PIPE_LAT-1:0]   vld_sr_q, vld_sr_d, last_sr_q, last_sr_d;
   logic [15:0]           mem_data_q [FIFO_DEPTH];
   logic [15:0]           mem_data_d [FIFO_DEPTH];
   logic                  mem_last_q [FIFO_DEPTH];
   logic                  mem_last_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
   logic [15:0]           pix_data_q, pix_data_d;
   logic                  pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
   logic                  busy_q, busy_d, frame_done_q, frame_done_d;

   logic [CNT_W-1:0]      inflight_c, fifo_cnt_c;
   logic [15:0]           comp_c;
   logic                  issue_c, push_c, pop_c, out_free_c, bypass_c, mem_wr_c, mem_rd_c;

   // Lowest-index enabled layer wins; background when nothing hits.
   always_comb begin
      comp_c = BG_COLOR;
      for (int i = int'(LAYER_NUM) - 1; i >= 0; i--) begin
         if (layer_enable[i]) comp_c = layer_color[16*i +: 16];
      end
   end

   always_comb begin
      inflight_c = '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) inflight_c = inflight_c + CNT_W'(vld_sr_q[i]);
      fifo_cnt_c = mem_cnt_q + CNT_W'(pix_valid_q);
      // Credits: every issued coordinate already owns a FIFO slot; pops free slots next cycle.
      issue_c    = (state_q == SCAN) && ((fifo_cnt_c + inflight_c) < CNT_W'(FIFO_DEPTH));
      push_c     = vld_sr_q[PIPE_LAT-1];
      pop_c      = pix_valid_q && pix_ready;
      out_free_c = !pix_valid_q || pop_c;
      bypass_c   = push_c && out_free_c && (mem_cnt_q == '0);
      mem_wr_c   = push_c && !bypass_c;
      mem_rd_c   = out_free_c && (mem_cnt_q != '0);
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      paint_x_d    = paint_x_q;
      paint_y_d    = paint_y_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      vld_sr_d     = (vld_sr_q << 1) | PIPE_LAT'(issue_c);
      last_sr_d    = (last_sr_q << 1) | PIPE_LAT'(issue_c && (x_q == X_MAX) && (y_q == Y_MAX));
      mem_data_d   = mem_data_q;
      mem_last_d   = mem_last_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_cnt_d    = mem_cnt_q + CNT_W'(mem_wr_c) - CNT_W'(mem_rd_c);
      pix_data_d   = pix_data_q;
      pix_valid_d  = pix_valid_q;
      pix_last_d   = pix_last_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               x_d     = '0;
               y_d     = '0;
               busy_d  = 1'b1;
            end
         end
         SCAN: begin
            if (issue_c) begin
               paint_x_d = x_q;
               paint_y_d = y_q;
               if (x_q == X_MAX) begin
                  x_d = '0;
                  if (y_q == Y_MAX) begin
                     y_d     = '0;
                     state_d = DRAIN;
                  end else begin
                     y_d = y_q + 16'd1;
                  end
               end else begin
                  x_d = x_q + 16'd1;
               end
            end
         end
         DRAIN: begin
            // Done once nothing is in flight or buffered and the final beat leaves this cycle.
            if ((inflight_c == '0) && (mem_cnt_q == '0) && out_free_c) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (mem_wr_c) begin
         mem_data_d[wr_ptr_q] = comp_c;
         mem_last_d[wr_ptr_q] = last_sr_q[PIPE_LAT-1];
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      end

      if (mem_rd_c) begin
         pix_data_d  = mem_data_q[rd_ptr_q];
         pix_last_d  = mem_last_q[rd_ptr_q];
         pix_valid_d = 1'b1;
         rd_ptr_d    = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      end else if (bypass_c) begin
         pix_data_d  = comp_c;
         pix_last_d  = last_sr_q[PIPE_LAT-1];
         pix_valid_d = 1'b1;
      end else if (pop_c) begin
         pix_valid_d = 1'b0;
         pix_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         paint_x_q    <= '0;
         paint_y_q    <= '0;
         vld_sr_q     <= '0;
         last_sr_q    <= '0;
         mem_data_q   <= '{default: '0};
         mem_last_q   <= '{default: 1'b0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_cnt_q    <= '0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         pix_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         paint_x_q    <= paint_x_d;
         paint_y_q    <= paint_y_d;
         vld_sr_q     <= vld_sr_d;
         last_sr_q    <= last_sr_d;
         mem_data_q   <= mem_data_d;
         mem_last_q   <= mem_last_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_cnt_q    <= mem_cnt_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         pix_last_q   <= pix_last_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign paint_x    = paint_x_q;
   assign paint_y    = paint_y_q;
   assign pix_data   = pix_data_q;
   assign pix_valid  = pix_valid_q;
   assign pix_last   = pix_last_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
endmodule
